// File: rtl/rx_oversample_if.sv
// Receive-side bundle for rx_oversample: serial line in, byte/handshake/error flags out.
interface rx_oversample_if;
  logic       rxd;
  logic       rd_en;
  logic [7:0] dout;
  logic       rx_rdy;
  logic       frm_err;
  logic       ovr_err;

  modport slave  (input rxd, input rd_en, output dout, output rx_rdy, output frm_err, output ovr_err);
  modport master (output rxd, output rd_en, input dout, input rx_rdy, input frm_err, input ovr_err);
endinterface

// File: rtl/rx_oversample.sv
// UART 8N1 receiver sampling rxd at bit centre on an OS_RATE x baud clock.
// Optional macro RX_MAJORITY_VOTE_EN: 3-sample majority vote at every sample point.
module rx_oversample #(
  parameter int OS_RATE = 16
) (
  input  logic            bclk,
  input  logic            rst,
  rx_oversample_if.slave  rx_if
);

  localparam int CW = $clog2(OS_RATE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OS_RATE / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(OS_RATE - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic [1:0]    sync_q;
  logic          rxd_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] os_ctr_q, os_ctr_d;
  logic [2:0]    bit_ctr_q, bit_ctr_d;
  logic [7:0]    shr_q, shr_d;
  logic [7:0]    dout_q, dout_d;
  logic          rdy_q, rdy_d;
  logic          frm_q, frm_d;
  logic          ovr_q, ovr_d;
  logic          sample;
  logic          good;

  assign rxd_s = sync_q[1];

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_if.rxd};
  end

`ifdef RX_MAJORITY_VOTE_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // hist_q[1] holds rxd_s from two edges ago, hist_q[0] from one edge ago
  logic [1:0] hist_q;

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= {hist_q[0], rxd_s};
  end

  assign sample = maj3(hist_q[1], hist_q[0], rxd_s);
`else
  assign sample = rxd_s;
`endif

  always_comb begin
    state_d   = state_q;
    os_ctr_d  = os_ctr_q;
    bit_ctr_d = bit_ctr_q;
    shr_d     = shr_q;
    dout_d    = dout_q;
    rdy_d     = rdy_q;
    frm_d     = frm_q;
    ovr_d     = ovr_q;
    good      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_d  = ST_START;
          os_ctr_d = '0;
        end
      end
      ST_START: begin
        if (os_ctr_q == HALF_M1) begin
          os_ctr_d  = '0;
          bit_ctr_d = '0;
          state_d   = sample ? ST_IDLE : ST_DATA;
        end else begin
          os_ctr_d = os_ctr_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (os_ctr_q == LAST) begin
          os_ctr_d  = '0;
          shr_d     = {sample, shr_q[7:1]};
          bit_ctr_d = bit_ctr_q + 3'd1;
          if (bit_ctr_q == 3'd7) state_d = ST_STOP;
        end else begin
          os_ctr_d = os_ctr_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (os_ctr_q == LAST) begin
          os_ctr_d = '0;
          if (sample) begin
            good    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frm_d   = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          os_ctr_d = os_ctr_q + CW'(1);
        end
      end
      ST_BREAK: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A good stop and an acknowledge on the same edge load the new byte without overrun
    if (good) begin
      dout_d = shr_q;
      rdy_d  = 1'b1;
      frm_d  = 1'b0;
      if (rdy_q) ovr_d = !rx_if.rd_en;
    end else if (rx_if.rd_en && rdy_q) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      os_ctr_q  <= '0;
      bit_ctr_q <= '0;
      shr_q     <= '0;
      dout_q    <= '0;
      rdy_q     <= 1'b0;
      frm_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_ctr_q  <= os_ctr_d;
      bit_ctr_q <= bit_ctr_d;
      shr_q     <= shr_d;
      dout_q    <= dout_d;
      rdy_q     <= rdy_d;
      frm_q     <= frm_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_if.dout    = dout_q;
  assign rx_if.rx_rdy  = rdy_q;
  assign rx_if.frm_err = frm_q;
  assign rx_if.ovr_err = ovr_q;

endmodule

// File: tb/tb_rx_oversample.sv
// Bench for rx_oversample: frame-level model predicting outputs per bclk, plus literal pins.
module tb_rx_oversample;

  localparam int OS  = 16;
  localparam int LAT = 2 + OS / 2 + 9 * OS;

  logic bclk = 1'b0;
  logic rst  = 1'b1;
  rx_oversample_if bus ();

  rx_oversample #(.OS_RATE(OS)) dut (.bclk(bclk), .rst(rst), .rx_if(bus));

  always #5 bclk = ~bclk;

  typedef struct {
    int         at;
    bit         good;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         cmp_en = 1'b0;
  logic [7:0] m_dout = 8'h00;
  logic       m_rdy = 1'b0, m_frm = 1'b0, m_ovr = 1'b0;
  int         rise_cyc = -1;
  logic       rdy_prev = 1'b0;

  // Frame-level model: a frame's effect lands on the edge its stop bit is sampled
  always @(posedge bclk) begin
    ev_t ev;
    bit  g, bd;
    cyc = cyc + 1;
    if (rst) begin
      m_dout = 8'h00; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
      evq.delete();
    end else begin
      g = 1'b0; bd = 1'b0;
      ev.at = 0; ev.good = 1'b0; ev.b = 8'h00;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        g  = ev.good;
        bd = !ev.good;
      end
      if (g) begin
        if (m_rdy) m_ovr = !bus.rd_en;
        m_dout = ev.b;
        m_rdy  = 1'b1;
        m_frm  = 1'b0;
      end else if (bus.rd_en && m_rdy) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
      if (bd) m_frm = 1'b1;
    end
  end

  always @(posedge rst) begin
    m_dout = 8'h00; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
    evq.delete();
  end

  always @(negedge bclk) begin
    if (cmp_en) begin
      checks++;
      if (bus.dout !== m_dout || bus.rx_rdy !== m_rdy || bus.frm_err !== m_frm || bus.ovr_err !== m_ovr) begin
        errors++;
        $display("FAIL cycle-compare @%0d: got dout=%h rdy=%b frm=%b ovr=%b, expected dout=%h rdy=%b frm=%b ovr=%b",
                 cyc, bus.dout, bus.rx_rdy, bus.frm_err, bus.ovr_err, m_dout, m_rdy, m_frm, m_ovr);
      end
    end
    if (bus.rx_rdy === 1'b1 && rdy_prev !== 1'b1) rise_cyc = cyc;
    rdy_prev = bus.rx_rdy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    bus.rxd = v;
    repeat (n) begin @(posedge bclk); #1; end
  endtask

  task automatic pulse_rd();
    bus.rd_en = 1'b1;
    @(posedge bclk); #1;
    bus.rd_en = 1'b0;
  endtask

  // Called #1 after an edge; level index i is what rxd shows at edge e0+i
  task automatic send_frame(input logic [7:0] b, input logic stop, input int low_after,
                            input int glitch, output int e0);
    ev_t ev;
    int  n;
    int  bp;
    logic lv;
    e0 = cyc + 1;
    ev.at = e0 + LAT; ev.good = stop; ev.b = b;
    evq.push_back(ev);
    n = 10 * OS + low_after;
    for (int i = 0; i < n; i++) begin
      bp = i / OS;
      if (bp == 0)      lv = 1'b0;
      else if (bp <= 8) lv = b[bp-1];
      else if (bp == 9) lv = stop;
      else              lv = 1'b0;
      if (i == glitch) lv = !lv;
      bus.rxd = lv;
      @(posedge bclk); #1;
    end
    bus.rxd = 1'b1;
  endtask

  initial begin
    int e0;
    int e0p;
    bus.rxd   = 1'b1;
    bus.rd_en = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge bclk);
    #1;
    check_lit("reset_dout", bus.dout, 8'h00);
    check_lit("reset_rdy", bus.rx_rdy, 0);
    check_lit("reset_frm", bus.frm_err, 0);
    check_lit("reset_ovr", bus.ovr_err, 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    hold(1'b1, 5);

    // 1: single frame latency and content
    send_frame(8'hA5, 1'b1, 0, -1, e0);
    check_lit("t1_latency", rise_cyc - e0, 154);
    check_lit("t1_dout", bus.dout, 8'hA5);
    check_lit("t1_frm", bus.frm_err, 0);
    pulse_rd();
    check_lit("t1_rdy_cleared", bus.rx_rdy, 0);

    // 2: back-to-back 0x00 / 0xFF with acknowledges
    send_frame(8'h00, 1'b1, 0, -1, e0);
    pulse_rd();
    check_lit("t2_dout00", bus.dout, 8'h00);
    send_frame(8'hFF, 1'b1, 0, -1, e0);
    check_lit("t2_doutFF", bus.dout, 8'hFF);
    check_lit("t2_errs", {bus.frm_err, bus.ovr_err}, 0);
    pulse_rd();

    // 3: short start glitch is rejected
    hold(1'b0, 4);
    hold(1'b1, 30);
    check_lit("t3_no_rdy", bus.rx_rdy, 0);
    send_frame(8'h3C, 1'b1, 0, -1, e0);
    check_lit("t3_dout", bus.dout, 8'h3C);
    pulse_rd();

    // 4: framing error with held-low line, then recovery
    send_frame(8'h55, 1'b0, 40, -1, e0);
    hold(1'b1, 20);
    check_lit("t4_frm_set", bus.frm_err, 1);
    check_lit("t4_rdy", bus.rx_rdy, 0);
    check_lit("t4_dout_kept", bus.dout, 8'h3C);
    send_frame(8'h12, 1'b1, 0, -1, e0);
    check_lit("t4_frm_clr", bus.frm_err, 0);
    check_lit("t4_dout", bus.dout, 8'h12);
    pulse_rd();

    // 5: overrun, then acknowledge coinciding with a good stop
    send_frame(8'h11, 1'b1, 0, -1, e0);
    send_frame(8'h22, 1'b1, 0, -1, e0);
    check_lit("t5_dout", bus.dout, 8'h22);
    check_lit("t5_rdy_ovr", {bus.rx_rdy, bus.ovr_err}, 2'b11);
    pulse_rd();
    check_lit("t5_cleared", {bus.rx_rdy, bus.ovr_err}, 2'b00);
    send_frame(8'h33, 1'b1, 0, -1, e0);
    e0p = cyc + 1;
    fork
      send_frame(8'h44, 1'b1, 0, -1, e0);
      begin
        while (cyc < e0p + LAT - 1) begin @(posedge bclk); #1; end
        pulse_rd();
      end
    join
    check_lit("t5_sim_dout", bus.dout, 8'h44);
    check_lit("t5_sim_rdy_ovr", {bus.rx_rdy, bus.ovr_err}, 2'b10);

    // 6: reset in the middle of 0xC3 data bits
    hold(1'b0, OS);
    hold(1'b1, 2 * OS);
    hold(1'b0, 20);
    rst = 1'b1;
    #1;
    check_lit("t6_async_reset", {bus.dout, bus.rx_rdy, bus.frm_err, bus.ovr_err}, 0);
    bus.rxd = 1'b1;
    hold(1'b1, 3);
    rst = 1'b0;
    hold(1'b1, 5);
    send_frame(8'h81, 1'b1, 0, -1, e0);
    check_lit("t6_dout", bus.dout, 8'h81);
    pulse_rd();

`ifdef RX_MAJORITY_VOTE_EN
    // 7: one-cycle high glitch at the centre of data bit 0
    send_frame(8'h00, 1'b1, 0, OS + OS / 2, e0);
    check_lit("t7_dout", bus.dout, 8'h00);
    check_lit("t7_rdy", bus.rx_rdy, 1);
    pulse_rd();
`endif

    hold(1'b1, 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
